// File: rtl/alu_sequencer.sv
// Command sequencer that drives an external combinational ALU and holds an
// accumulator plus ZNCV flags; MUL is done by shift-and-add through the same ALU.
module alu_sequencer #(
  parameter int DATA_WIDTH = 8
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  cmd_valid,
  output logic                  cmd_ready,
  input  logic [3:0]            cmd_op,
  input  logic [DATA_WIDTH-1:0] cmd_b,
  output logic [DATA_WIDTH-1:0] alu_op_a,
  output logic [DATA_WIDTH-1:0] alu_op_b,
  output logic [2:0]            alu_func,
  input  logic [DATA_WIDTH-1:0] alu_out,
  input  logic                  alu_carry_flag,
  input  logic                  alu_signed_overflow,
  output logic [DATA_WIDTH-1:0] acc,
  output logic                  flag_z,
  output logic                  flag_n,
  output logic                  flag_c,
  output logic                  flag_v,
  output logic                  done,
  output logic                  err
);

  // state | meaning
  // IDLE  | waiting for a command, cmd_ready high
  // EXEC  | single ALU operation, writeback on exit
  // MUL   | DATA_WIDTH shift-and-add steps, writeback on last step
  // DONE  | done (and err for illegal) pulse, then back to IDLE

  localparam int CNT_W = $clog2(DATA_WIDTH + 1);
  localparam logic [2:0] FUNC_ADD = 3'b000;
  localparam logic [3:0] OP_MUL   = 4'b1000;

  typedef enum logic [1:0] {IDLE, EXEC, MUL, DONE} state_t;

  state_t                state, state_nxt;
  logic [3:0]            op_q;
  logic [DATA_WIDTH-1:0] b_q;
  logic [DATA_WIDTH-1:0] p_q, m_q, q_q;
  logic [CNT_W-1:0]      cnt_q;
  logic [DATA_WIDTH-1:0] p_nxt;
  logic                  accept;
  logic                  illegal;
  logic                  is_arith;

  assign accept   = cmd_valid && cmd_ready;
  assign illegal  = op_q[3] ? (op_q[2:0] != 3'b000) : (op_q[2:0] == 3'b011);
  assign is_arith = !op_q[3] && (op_q[2:1] == 2'b00);
  assign p_nxt    = q_q[0] ? alu_out : p_q;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: if (accept) state_nxt = (cmd_op == OP_MUL) ? MUL : EXEC;
      EXEC: state_nxt = DONE;
      MUL:  if (cnt_q == '0) state_nxt = DONE;
      DONE: state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    cmd_ready = (state == IDLE);
    done      = (state == DONE);
    err       = (state == DONE) && illegal;
    alu_op_a  = acc;
    alu_op_b  = '0;
    alu_func  = FUNC_ADD;
    case (state)
      EXEC: begin
        alu_op_b = b_q;
        alu_func = op_q[2:0];
      end
      MUL: begin
        alu_op_a = p_q;
        alu_op_b = m_q;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      op_q   <= '0;
      b_q    <= '0;
      p_q    <= '0;
      m_q    <= '0;
      q_q    <= '0;
      cnt_q  <= '0;
      acc    <= '0;
      flag_z <= 1'b0;
      flag_n <= 1'b0;
      flag_c <= 1'b0;
      flag_v <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (accept) begin
            op_q  <= cmd_op;
            b_q   <= cmd_b;
            p_q   <= '0;
            m_q   <= acc;
            q_q   <= cmd_b;
            cnt_q <= CNT_W'(DATA_WIDTH - 1);
          end
        end
        EXEC: begin
          if (!illegal) begin
            acc    <= alu_out;
            flag_z <= (alu_out == '0);
            flag_n <= alu_out[DATA_WIDTH-1];
            if (is_arith) begin
              flag_c <= alu_carry_flag;
              flag_v <= alu_signed_overflow;
            end
          end
        end
        MUL: begin
          p_q   <= p_nxt;
          m_q   <= m_q << 1;
          q_q   <= q_q >> 1;
          cnt_q <= cnt_q - CNT_W'(1);
          // last step: the final partial product goes straight to acc
          if (cnt_q == '0) begin
            acc    <= p_nxt;
            flag_z <= (p_nxt == '0);
            flag_n <= p_nxt[DATA_WIDTH-1];
            flag_c <= 1'b0;
            flag_v <= 1'b0;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_alu_sequencer.sv
// Bench for alu_sequencer: behavioural ALU, reference accumulator model and a
// scoreboard of expected results checked when done pulses.
module tb_alu_sequencer;

  localparam int DW = 8;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          cmd_valid;
  logic          cmd_ready;
  logic [3:0]    cmd_op;
  logic [DW-1:0] cmd_b;
  logic [DW-1:0] alu_op_a, alu_op_b, alu_out;
  logic [2:0]    alu_func;
  logic          alu_carry_flag, alu_signed_overflow;
  logic [DW-1:0] acc;
  logic          flag_z, flag_n, flag_c, flag_v, done, err;

  alu_sequencer #(.DATA_WIDTH(DW)) dut (
    .clk(clk), .rst_n(rst_n), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_op(cmd_op), .cmd_b(cmd_b), .alu_op_a(alu_op_a), .alu_op_b(alu_op_b),
    .alu_func(alu_func), .alu_out(alu_out), .alu_carry_flag(alu_carry_flag),
    .alu_signed_overflow(alu_signed_overflow), .acc(acc), .flag_z(flag_z),
    .flag_n(flag_n), .flag_c(flag_c), .flag_v(flag_v), .done(done), .err(err)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // external ALU
  logic [DW:0] alu_sum;
  always_comb begin
    alu_sum             = '0;
    alu_out             = '0;
    alu_carry_flag      = 1'b0;
    alu_signed_overflow = 1'b0;
    case (alu_func)
      3'b000: begin
        alu_sum             = {1'b0, alu_op_a} + {1'b0, alu_op_b};
        alu_out             = alu_sum[DW-1:0];
        alu_carry_flag      = alu_sum[DW];
        alu_signed_overflow = (alu_op_a[DW-1] == alu_op_b[DW-1]) && (alu_out[DW-1] != alu_op_a[DW-1]);
      end
      3'b001: begin
        alu_out             = alu_op_a - alu_op_b;
        alu_carry_flag      = (alu_op_a >= alu_op_b);
        alu_signed_overflow = (alu_op_a[DW-1] != alu_op_b[DW-1]) && (alu_out[DW-1] != alu_op_a[DW-1]);
      end
      3'b010: alu_out = alu_op_a & alu_op_b;
      3'b100: alu_out = alu_op_a | alu_op_b;
      3'b101: alu_out = alu_op_a ^ alu_op_b;
      3'b110: alu_out = alu_op_b;
      3'b111: alu_out = ~alu_op_b;
      default: alu_out = 8'hA5;
    endcase
  end

  int n_chk  = 0;
  int n_fail = 0;

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", tag, act, exp, $time);
    end
  endtask

  typedef struct {
    logic [DW-1:0] acc;
    logic [3:0]    flags;
    logic          err;
    int            lat;
    int            acc_cyc;
  } exp_t;

  exp_t          sb[$];
  logic [DW-1:0] m_acc;
  logic          m_z, m_n, m_c, m_v;
  int            prev_acc_cyc = 0;
  int            last_gap = 0;

  always @(negedge clk) begin
    exp_t          e;
    exp_t          got;
    logic [DW-1:0] a, b, r;
    logic [DW:0]   s9;
    logic [2*DW-1:0] prod;
    logic          ill;
    int            si;
    if (!rst_n) begin
      sb.delete();
      m_acc = '0;
      {m_z, m_n, m_c, m_v} = 4'b0000;
    end else begin
      if (sb.size() != 0) chk("ready_busy", cmd_ready, 0);
      if (!done) chk("err_without_done", err, 0);
      if (done) begin
        if (sb.size() == 0) begin
          chk("done_spurious", done, 0);
        end else begin
          got = sb.pop_front();
          chk("sb_acc", acc, got.acc);
          chk("sb_flags", {flag_z, flag_n, flag_c, flag_v}, got.flags);
          chk("sb_err", err, got.err);
          chk("sb_latency", cyc - got.acc_cyc, got.lat);
        end
      end
      if (cmd_valid && cmd_ready) begin
        a = m_acc;
        b = cmd_b;
        r = a;
        e.err = 1'b0;
        e.lat = 2;
        ill = cmd_op[3] ? (cmd_op != 4'b1000) : (cmd_op[2:0] == 3'b011);
        if (cmd_op == 4'b1000) begin
          prod = a * b;
          r = prod[DW-1:0];
          m_c = 1'b0;
          m_v = 1'b0;
          e.lat = DW + 1;
        end else if (ill) begin
          e.err = 1'b1;
        end else begin
          case (cmd_op[2:0])
            3'b000: begin
              s9 = {1'b0, a} + {1'b0, b};
              r = s9[DW-1:0];
              m_c = s9[DW];
              si = int'($signed(a)) + int'($signed(b));
              m_v = (si > 127) || (si < -128);
            end
            3'b001: begin
              r = a - b;
              m_c = (a >= b);
              si = int'($signed(a)) - int'($signed(b));
              m_v = (si > 127) || (si < -128);
            end
            3'b010: r = a & b;
            3'b100: r = a | b;
            3'b101: r = a ^ b;
            3'b110: r = b;
            default: r = ~b;
          endcase
        end
        if (!ill) begin
          m_acc = r;
          m_z = (r == '0);
          m_n = r[DW-1];
        end
        e.acc = m_acc;
        e.flags = {m_z, m_n, m_c, m_v};
        e.acc_cyc = cyc;
        sb.push_back(e);
        last_gap = cyc - prev_acc_cyc;
        prev_acc_cyc = cyc;
      end
    end
  end

  // all stimulus tasks start and end at posedge+1
  task automatic send(input logic [3:0] op, input logic [DW-1:0] b);
    int t = 0;
    while (!cmd_ready && t < 40) begin
      @(posedge clk); #1;
      t++;
    end
    if (!cmd_ready) chk("ready_timeout", cmd_ready, 1);
    cmd_valid = 1'b1;
    cmd_op    = op;
    cmd_b     = b;
    @(posedge clk); #1;
    cmd_valid = 1'b0;
  endtask

  task automatic wait_done();
    int t = 0;
    while (!done && t < 40) begin
      @(posedge clk); #1;
      t++;
    end
    if (!done) chk("done_timeout", done, 1);
  endtask

  task automatic run(input logic [3:0] op, input logic [DW-1:0] b);
    send(op, b);
    wait_done();
    @(posedge clk); #1;
  endtask

  initial begin
    rst_n     = 1'b0;
    cmd_valid = 1'b0;
    cmd_op    = '0;
    cmd_b     = '0;
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    @(negedge clk);
    chk("rst_acc", acc, 0);
    chk("rst_flags", {flag_z, flag_n, flag_c, flag_v}, 0);
    chk("rst_ready", cmd_ready, 1);
    chk("rst_done", done, 0);
    @(posedge clk); #1;

    send(4'b0110, 8'h7F); wait_done();
    chk("copyb_acc", acc, 8'h7F);
    chk("copyb_flags", {flag_z, flag_n, flag_c, flag_v}, 4'b0000);
    @(posedge clk); #1;

    send(4'b0000, 8'h01); wait_done();
    chk("add_acc", acc, 8'h80);
    chk("add_flags", {flag_z, flag_n, flag_c, flag_v}, 4'b0101);
    @(posedge clk); #1;

    send(4'b0001, 8'h80); wait_done();
    chk("sub_acc", acc, 8'h00);
    chk("sub_flags", {flag_z, flag_n, flag_c, flag_v}, 4'b1010);
    @(posedge clk); #1;

    run(4'b0110, 8'h0D);
    send(4'b1000, 8'h0B); wait_done();
    chk("mul_acc", acc, 8'h8F);
    chk("mul_flags", {flag_z, flag_n, flag_c, flag_v}, 4'b0100);
    @(posedge clk); #1;

    run(4'b0110, 8'h55);
    send(4'b0011, 8'h12); wait_done();
    chk("ill_reserved_err", err, 1);
    chk("ill_reserved_acc", acc, 8'h55);
    @(posedge clk); #1;
    send(4'b1010, 8'h34); wait_done();
    chk("ill_high_err", err, 1);
    chk("ill_high_acc", acc, 8'h55);
    chk("ill_high_flags", {flag_z, flag_n, flag_c, flag_v}, 4'b0000);
    @(posedge clk); #1;

    run(4'b0000, 8'hAB);
    run(4'b0111, 8'h0F);
    chk("notb_flags", {flag_z, flag_n, flag_c, flag_v}, 4'b0110);
    send(4'b1000, 8'h03);
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(negedge clk);
    chk("abort_acc", acc, 0);
    chk("abort_flags", {flag_z, flag_n, flag_c, flag_v}, 0);
    chk("abort_ready", cmd_ready, 1);
    chk("abort_done", done, 0);
    @(posedge clk); #1;

    run(4'b0110, 8'hFF);
    cmd_valid = 1'b1;
    cmd_op    = 4'b0000;
    cmd_b     = 8'h01;
    repeat (2) @(posedge clk);
    #1;
    chk("b2b_first_done", done, 1);
    chk("b2b_first_acc", acc, 8'h00);
    chk("b2b_first_flags", {flag_z, flag_c}, 2'b11);
    repeat (2) @(posedge clk);
    #1 cmd_valid = 1'b0;
    wait_done();
    chk("b2b_second_acc", acc, 8'h01);
    chk("b2b_second_flags", {flag_z, flag_c}, 2'b00);
    chk("b2b_gap", last_gap, 3);
    @(posedge clk); #1;

    for (int i = 0; i < 16; i++) begin
      run(4'($urandom_range(0, 15)), 8'($urandom_range(0, 255)));
    end
    for (int i = 0; i < 4; i++) begin
      run(4'b0110, 8'($urandom_range(1, 255)));
      run(4'b1000, 8'($urandom_range(0, 255)));
    end

    repeat (3) @(posedge clk);
    chk("sb_drained", sb.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
